// File: rtl/i2c_pkg.sv
// Shared types, constants and frame-length helper for the write-only I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    STOP,
    DONE
  } state_e;

  localparam int unsigned QUARTERS  = 4;
  localparam int unsigned SLOT_BITS = 9;

  localparam int unsigned QW    = 2;
  localparam int unsigned BITW  = 4;
  localparam int unsigned BYTEW = 3;

  // en periods from the accept tick to the tick on which ack rises
  function automatic int unsigned frame_len(input int unsigned nbytes);
    return QUARTERS + QUARTERS * SLOT_BITS * (nbytes + 1) + QUARTERS;
  endfunction

endpackage

// File: rtl/i2c_quarter_seq.sv
// Quarter / bit-slot / byte counters for the I2C master, advancing only on en ticks.
module i2c_quarter_seq
  import i2c_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic            step,
  output logic [QW-1:0]   qtr,
  output logic [BITW-1:0] bit_nxt_c,
  output logic            qtr_tc_c,
  output logic            slot_tc_c,
  output logic            frame_tc_c,
  output logic            ack_slot_c
);

  logic [QW-1:0]    qtr_q,  qtr_d;
  logic [BITW-1:0]  bit_q,  bit_d;
  logic [BYTEW-1:0] byte_q, byte_d;

  always_comb begin
    qtr_tc_c   = (qtr_q == QW'(QUARTERS - 1));
    ack_slot_c = (bit_q == BITW'(SLOT_BITS - 1));
    slot_tc_c  = qtr_tc_c && ack_slot_c;
    frame_tc_c = slot_tc_c && (byte_q == BYTEW'(NBYTES));
  end

  // quarter wraps into the bit slot, the ACK slot wraps into the byte
  always_comb begin
    qtr_d  = qtr_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    if (clr) begin
      qtr_d  = '0;
      bit_d  = '0;
      byte_d = '0;
    end else if (step) begin
      if (qtr_tc_c) begin
        qtr_d = '0;
        if (ack_slot_c) begin
          bit_d  = '0;
          byte_d = byte_q + BYTEW'(1);
        end else begin
          bit_d = bit_q + BITW'(1);
        end
      end else begin
        qtr_d = qtr_q + QW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qtr_q  <= '0;
      bit_q  <= '0;
      byte_q <= '0;
    end else if (en) begin
      qtr_q  <= qtr_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
    end
  end

  assign qtr       = qtr_q;
  assign bit_nxt_c = bit_d;

endmodule

// File: rtl/i2c_master_wr.sv
// Write-only I2C master: START, addr+W, NBYTES data bytes, STOP, then a one-period ack.
// Optional slave-NACK abort is enabled by defining I2C_NACK_CHECK_EN.
module i2c_master_wr
  import i2c_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [6:0]             addr,
  input  logic [NBYTES-1:0][7:0] wdata,
  input  logic                   req,
  output logic                   ack,
  output logic                   scl_o,
  output logic                   sda_oe,
  input  logic                   sda_i,
  output logic                   nack
);

  localparam int unsigned FRAME_W = 8 * (NBYTES + 1);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   sh_q,    sh_d;
  logic                 scl_q,   scl_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 ack_q,   ack_d;
  logic                 nack_q,  nack_d;

  logic                 seq_clr;
  logic                 seq_step;
  logic [QW-1:0]        qtr;
  logic [BITW-1:0]      bit_nxt_c;
  logic                 qtr_tc_c;
  logic                 slot_tc_c;
  logic                 frame_tc_c;
  logic                 ack_slot_c;

  i2c_quarter_seq #(
    .NBYTES (NBYTES)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (seq_clr),
    .step       (seq_step),
    .qtr        (qtr),
    .bit_nxt_c  (bit_nxt_c),
    .qtr_tc_c   (qtr_tc_c),
    .slot_tc_c  (slot_tc_c),
    .frame_tc_c (frame_tc_c),
    .ack_slot_c (ack_slot_c)
  );

`ifndef I2C_NACK_CHECK_EN
  logic nack_unused;
  assign nack_unused = &{sda_i, ack_slot_c};
`endif

  // Output registers hold the levels of the quarter being entered on this tick.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    scl_d    = scl_q;
    sda_oe_d = sda_oe_q;
    ack_d    = 1'b0;
    nack_d   = nack_q;
    seq_clr  = 1'b0;
    seq_step = 1'b0;

    case (state_q)
      IDLE: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        if (req) begin
          state_d = START;
          sh_d    = {addr, 1'b0, wdata};
          nack_d  = 1'b0;
          seq_clr = 1'b1;
        end
      end

      START: begin
        if (qtr_tc_c) begin
          state_d  = BIT;
          seq_clr  = 1'b1;
          scl_d    = 1'b0;
          sda_oe_d = ~sh_q[FRAME_W-1];
          sh_d     = {sh_q[FRAME_W-2:0], 1'b0};
        end else begin
          seq_step = 1'b1;
          scl_d    = (qtr != QW'(2));
          sda_oe_d = 1'b1;
        end
      end

      BIT: begin
        if (slot_tc_c && (frame_tc_c || nack_q)) begin
          state_d  = STOP;
          seq_clr  = 1'b1;
          scl_d    = 1'b0;
          sda_oe_d = 1'b1;
        end else begin
          seq_step = 1'b1;
          if (qtr_tc_c) begin
            scl_d = 1'b0;
            // next slot is either the ACK slot (released) or the next data bit
            if (bit_nxt_c == BITW'(SLOT_BITS - 1)) begin
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~sh_q[FRAME_W-1];
              sh_d     = {sh_q[FRAME_W-2:0], 1'b0};
            end
          end else begin
            scl_d = (qtr != '0);
          end
`ifdef I2C_NACK_CHECK_EN
          if (ack_slot_c && (qtr == QW'(2)) && sda_i) begin
            nack_d = 1'b1;
          end
`endif
        end
      end

      STOP: begin
        if (qtr_tc_c) begin
          state_d  = DONE;
          seq_clr  = 1'b1;
          ack_d    = 1'b1;
          scl_d    = 1'b1;
          sda_oe_d = 1'b0;
        end else begin
          seq_step = 1'b1;
          scl_d    = 1'b1;
          sda_oe_d = (qtr == '0);
        end
      end

      DONE: begin
        state_d  = IDLE;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end

      default: begin
        state_d  = IDLE;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
    end else if (en) begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
    end
  end

  assign ack    = ack_q;
  assign scl_o  = scl_q;
  assign sda_oe = sda_oe_q;
  assign nack   = nack_q;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Self-checking bench for i2c_master_wr with a per-en-tick waveform model and SDA byte decoder.
module tb_i2c_master_wr;

  localparam int NB = 2;
`ifdef I2C_NACK_CHECK_EN
  localparam bit NACK_EN = 1'b1;
`else
  localparam bit NACK_EN = 1'b0;
`endif

  typedef logic [NB-1:0][7:0] wd_t;
  typedef struct packed {
    logic scl;
    logic oe;
    logic ack;
    logic nack;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en;
  logic       req;
  logic       sda_i;
  logic [6:0] addr;
  wd_t        wdata;
  logic       ack, scl_o, sda_oe, nack;

  always #5 clk = ~clk;

  i2c_master_wr #(.NBYTES(NB)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .addr   (addr),
    .wdata  (wdata),
    .req    (req),
    .ack    (ack),
    .scl_o  (scl_o),
    .sda_oe (sda_oe),
    .sda_i  (sda_i),
    .nack   (nack)
  );

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  obs_t exp = 4'b1000;
  int   en_ticks = 0;
  int   accept_cnt = 0;
  int   last_accept_tick = 0;
  int   prev_accept_tick = 0;
  int   ack_cnt = 0;
  int   ack_rise_tick = 0;
  logic bits[$];
  logic scl_prev = 1'b1;
  int   en_mode = 0;
  int   en_div = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic void put(input logic s, input logic o, input logic a, input logic n);
    exp_q.push_back(obs_t'({s, o, a, n}));
  endfunction

  // Expected (scl, sda_oe, ack, nack) for every en tick from accept up to the idle tick after ack.
  function automatic void build_frame(input logic [6:0] a, input wd_t w, input logic nk);
    logic [7:0] bytes [NB+1];
    int   nsent;
    logic nf;
    bytes[0] = {a, 1'b0};
    for (int k = 0; k < NB; k++) bytes[k+1] = w[NB-1-k];
    nsent = (NACK_EN && nk) ? 1 : NB + 1;
    nf = 1'b0;
    put(1, 0, 0, nf); put(1, 1, 0, nf); put(1, 1, 0, nf); put(0, 1, 0, nf);
    for (int b = 0; b < nsent; b++) begin
      for (int i = 0; i < 8; i++)
        for (int q = 0; q < 4; q++) put(q >= 2, ~bytes[b][7-i], 0, nf);
      for (int q = 0; q < 4; q++) begin
        if (NACK_EN && nk && q == 3) nf = 1'b1;
        put(q >= 2, 0, 0, nf);
      end
    end
    put(0, 1, 0, nf); put(1, 1, 0, nf); put(1, 0, 0, nf); put(1, 0, 0, nf);
    put(1, 0, 1, nf);
    put(1, 0, 0, nf);
  endfunction

  // en pattern generator
  initial begin
    en = 1'b0;
    forever begin
      @(negedge clk);
      case (en_mode)
        0: en = 1'b1;
        1: begin
          en_div = (en_div + 1) % 3;
          en = (en_div == 0);
        end
        default: en = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // Model step on each edge, then compare every cycle and decode SDA at SCL rises.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp = 4'b1000;
    end else if (en) begin
      en_ticks++;
      if (exp_q.size() == 0 && req) begin
        build_frame(addr, wdata, sda_i);
        accept_cnt++;
        prev_accept_tick = last_accept_tick;
        last_accept_tick = en_ticks;
        bits.delete();
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        if (exp.ack) begin
          ack_cnt++;
          ack_rise_tick = en_ticks;
        end
      end
    end
    #1;
    checks++;
    if ({scl_o, sda_oe, ack, nack} !== exp) begin
      errors++;
      $display("FAIL outputs t=%0t tick=%0d: got scl=%b oe=%b ack=%b nack=%b want scl=%b oe=%b ack=%b nack=%b",
               $time, en_ticks, scl_o, sda_oe, ack, nack, exp.scl, exp.oe, exp.ack, exp.nack);
    end
    if (scl_o && !scl_prev) bits.push_back(~sda_oe);
    scl_prev = scl_o;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: frame still running after %0d cycles", budget);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input wd_t w, input logic nk, input int lat);
    int start;
    int n;
    @(negedge clk);
    addr = a; wdata = w; sda_i = nk; req = 1'b1;
    start = accept_cnt;
    n = 0;
    while (accept_cnt == start && n < 400) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    addr = 7'($urandom);
    wdata = wd_t'($urandom);
    if (accept_cnt == start) begin
      chk("accept_timeout", 0, 1);
    end else begin
      wait_idle(4000);
      chk("latency", ack_rise_tick - last_accept_tick, lat);
    end
  endtask

  task automatic check_frame(input logic [6:0] a, input wd_t w);
    logic [7:0] want, got;
    if (bits.size() < 9 * (NB + 1)) begin
      chk("decode_len", bits.size(), 9 * (NB + 1));
    end else begin
      for (int b = 0; b <= NB; b++) begin
        want = (b == 0) ? {a, 1'b0} : w[NB-b];
        got = '0;
        for (int i = 0; i < 8; i++) got = {got[6:0], bits[9*b+i]};
        chk($sformatf("byte%0d", b), got, want);
        chk($sformatf("ackslot%0d_released", b), bits[9*b+8], 1);
      end
    end
  endtask

  logic [15:0] cfg [9] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                           16'h0679, 16'h0812, 16'h0A00, 16'h1201};

  initial begin
    int start;
    int n;
    int up_state;
    int ack0;
    wd_t w;
    logic [6:0] a;

    req = 1'b0; sda_i = 1'b0; addr = '0; wdata = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_o, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_ack", ack, 0);
    chk("rst_nack", nack, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // frame content
    do_write(7'h1A, 16'h1E00, 1'b0, 116);
    check_frame(7'h1A, 16'h1E00);

    // stalled en, fixed and random gaps
    en_mode = 1;
    do_write(7'h55, 16'hA53C, 1'b0, 116);
    check_frame(7'h55, 16'hA53C);
    en_mode = 2;
    do_write(7'h2B, 16'h0FF0, 1'b0, 116);
    check_frame(7'h2B, 16'h0FF0);

    // busy: req held high through a frame
    en_mode = 0;
    @(negedge clk);
    addr = 7'h1A; wdata = 16'h1234; sda_i = 1'b0; req = 1'b1;
    start = accept_cnt;
    n = 0;
    while (accept_cnt < start + 2 && n < 600) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    chk("busy_accepts", accept_cnt - start, 2);
    chk("busy_gap", last_accept_tick - prev_accept_tick, 118);
    wait_idle(4000);

    // reset mid-frame
    @(negedge clk);
    addr = 7'h33; wdata = 16'hBEEF; req = 1'b1;
    start = accept_cnt;
    n = 0;
    while (accept_cnt == start && n < 50) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    n = 0;
    while (en_ticks < last_accept_tick + 40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_tick", en_ticks - last_accept_tick, 40);
    reset = 1'b1;
    #1;
    chk("midrst_scl", scl_o, 1);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_ack", ack, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_write(7'h33, 16'hBEEF, 1'b0, 116);
    check_frame(7'h33, 16'hBEEF);

    // upstream configuration sequence: nine register writes
    up_state = 0;
    ack0 = ack_cnt;
    for (int i = 0; i < 9; i++) begin
      en_mode = i % 3;
      do_write(7'h1A, cfg[i], 1'b0, 116);
      check_frame(7'h1A, cfg[i]);
      if (ack_cnt > ack0 + up_state) up_state++;
    end
    chk("upstream_final_state", up_state, 9);
    chk("upstream_acks", ack_cnt - ack0, 9);

    // slave NACK in the first ACK slot
    en_mode = 0;
    do_write(7'h1A, 16'h5A5A, 1'b1, NACK_EN ? 44 : 116);
    chk("nack_flag", nack, NACK_EN ? 1 : 0);
    do_write(7'h1A, 16'h0102, 1'b0, 116);
    chk("nack_cleared", nack, 0);
    check_frame(7'h1A, 16'h0102);

    // random traffic
    for (int i = 0; i < 5; i++) begin
      en_mode = $urandom_range(0, 2);
      a = 7'($urandom);
      w = wd_t'($urandom);
      do_write(a, w, 1'b0, 116);
      check_frame(a, w);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
